// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial FSM states and counter sizing helper.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin_in, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, bo_bit;
  logic [WIDTH-1:0] diff_shift;

  full_subtractor u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (bor_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shift = d_bit;
    end else begin : g_wn
      assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = bin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        diff_d = diff_shift;
        bor_d  = bo_bit;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1, bin_in = 1'b0;
  logic       in_ready, out_valid, borrow;
  logic [7:0] a = '0, b = '0, diff;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b1, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       in_ready1, out_valid1, borrow1;

  int         n_cmp = 0, n_err = 0;
  logic [8:0] expq[$];
  logic [8:0] mon_e;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin_in(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .borrow(borrow1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  // Monitor: every accepted result is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL result: got %0h expected none queued", {borrow, diff});
      end else begin
        mon_e = expq.pop_front();
        chk("result", {23'd0, borrow, diff}, {23'd0, mon_e});
      end
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic bi,
                      input bit push, input logic [8:0] exp);
    int t = 0;
    a = aa; b = bb; bin_in = bi; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) expq.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [7:0] ra, rb;
    logic       rbi;

    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and basic result
    send(8'h5A, 8'h3C, 1'b0, 1'b1, 9'h01E);
    wait_out(cyc);
    chk("latency", cyc, 32'd8);
    @(posedge clk); #1;

    send(8'h10, 8'h0F, 1'b1, 1'b1, 9'h000);
    wait_out(cyc);
    @(posedge clk); #1;
    send(8'hFF, 8'h00, 1'b1, 1'b1, 9'h0FE);
    wait_out(cyc);
    @(posedge clk); #1;
    send(8'h00, 8'hFF, 1'b1, 1'b1, 9'h100);
    wait_out(cyc);
    @(posedge clk); #1;
    send(8'h80, 8'h7F, 1'b0, 1'b1, 9'h001);
    wait_out(cyc);
    @(posedge clk); #1;

    // Backpressure hold while a new operand waits
    out_ready = 1'b0;
    send(8'h00, 8'h01, 1'b0, 1'b1, 9'h1FF);
    wait_out(cyc);
    a = 8'h10; b = 8'h0F; bin_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_diff", {24'd0, diff}, 32'hFF);
      chk("hold_borrow", {31'd0, borrow}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_hs", {31'd0, in_ready}, 32'd1);
    expq.push_back(9'h000);
    @(posedge clk); #1;
    chk("accepted_in_idle", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_out(cyc);
    @(posedge clk); #1;

    // Reset in the 3rd RUN cycle discards the operation
    send(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 9'h000);
    wait_out(cyc);
    chk("latency_after_abort", cyc, 32'd8);
    @(posedge clk); #1;

    // WIDTH=1 instance: 0 - 1 - 1
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b1; in_valid1 = 1'b1;
    chk("w1_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("w1_latency", cyc, 32'd1);
    chk("w1_diff", {31'd0, diff1}, 32'd0);
    chk("w1_borrow", {31'd0, borrow1}, 32'd1);
    @(posedge clk); #1;

    // Random sweep against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      send(ra, rb, rbi, 1'b1, model(ra, rb, rbi));
    end
    cyc = 0;
    while (expq.size() != 0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drain", expq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
